// File: rtl/cactus_s_ip.sv
// Read-only 24x49 small-cactus sprite, 12-bit bbbb_gggg_rrrr pixels.
// Contents are a fixed rectangle decode of (row, col); output is registered.
module cactus_s_ip #(
    parameter int          SPR_W = 24,
    parameter int          SPR_H = 49,
    parameter logic [11:0] FG    = 12'h555,
    parameter logic [11:0] BG    = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addra,
    output logic [11:0] douta
);

    localparam int DEPTH = SPR_W * SPR_H;

    logic [15:0] row;
    logic [15:0] col;
    logic        in_range;
    logic        is_fg;
    logic [11:0] pix;
    // Power-up value so the output reads as background before the first reset.
    logic [11:0] douta_q = BG;

    function automatic logic in_box(
        input logic [15:0] r,
        input logic [15:0] c,
        input int          r0,
        input int          r1,
        input int          c0,
        input int          c1
    );
        return (int'(r) >= r0) && (int'(r) <= r1) &&
               (int'(c) >= c0) && (int'(c) <= c1);
    endfunction

    always_comb begin
        in_range = int'(addra) < DEPTH;
        row      = addra / 16'(SPR_W);
        col      = addra % 16'(SPR_W);
        is_fg    = in_box(row, col,  0, 48,  9, 14)    // trunk
                 | in_box(row, col, 14, 30,  2,  5)    // left arm
                 | in_box(row, col, 27, 30,  6,  8)    // left connector
                 | in_box(row, col,  8, 24, 18, 21)    // right arm
                 | in_box(row, col, 21, 24, 15, 17);   // right connector
        pix      = (in_range && is_fg) ? FG : BG;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            douta_q <= BG;
        end else begin
            douta_q <= pix;
        end
    end

    assign douta = douta_q;

endmodule

// File: tb/tb_cactus_s_ip.sv
// Randomised and directed checks of cactus_s_ip against a rectangle-list model.
module tb_cactus_s_ip;

    localparam logic [11:0] FG = 12'h555;
    localparam logic [11:0] BG = 12'hfff;

    // Region table: row lo/hi, col lo/hi.
    localparam int RLO[5] = '{ 0, 14, 27,  8, 21};
    localparam int RHI[5] = '{48, 30, 30, 24, 24};
    localparam int CLO[5] = '{ 9,  2,  6, 18, 15};
    localparam int CHI[5] = '{14,  5,  8, 21, 17};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addra = 16'd0;
    logic [11:0] douta;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_val = BG;

    cactus_s_ip dut (
        .clk   (clk),
        .rst   (rst),
        .addra (addra),
        .douta (douta)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_pix(input int a);
        int r;
        int c;
        if (a >= 24 * 49) return BG;
        r = a / 24;
        c = a % 24;
        for (int k = 0; k < 5; k++)
            if (r >= RLO[k] && r <= RHI[k] && c >= CLO[k] && c <= CHI[k]) return FG;
        return BG;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected output: whatever the last edge should have loaded.
    always @(posedge clk) exp_val = rst ? BG : model_pix(int'(addra));

    always @(negedge clk) check("stream", douta, exp_val);

    task automatic lit(input string name, input logic [15:0] a, input logic [11:0] req);
        @(posedge clk);
        #1;
        addra = a;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check(name, douta, req);
    endtask

    initial begin
        int fg_cnt;
        int m_cnt;

        #1;
        check("pre_reset", douta, BG);

        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_reset", douta, BG);
        addra = 16'd9;
        rst   = 1'b0;
        #2;
        check("latency_hold", douta, BG);
        @(posedge clk);
        #1;
        check("first_after_reset", douta, FG);

        lit("addr_0",    16'd0,    BG);
        lit("addr_9",    16'd9,    FG);
        lit("addr_14",   16'd14,   FG);
        lit("addr_15",   16'd15,   BG);
        lit("addr_1166", 16'd1166, FG);
        lit("addr_1175", 16'd1175, BG);
        lit("addr_483",  16'd483,  FG);
        lit("addr_259",  16'd259,  FG);
        lit("addr_243",  16'd243,  BG);
        lit("addr_655",  16'd655,  FG);
        lit("addr_520",  16'd520,  FG);
        lit("oor_1176",  16'd1176, BG);
        lit("oor_4000",  16'd4000, BG);
        lit("oor_ffff",  16'hFFFF, BG);

        // Pin the model: 294+68+12+68+12 foreground pixels.
        m_cnt = 0;
        for (int a = 0; a < 1176; a++) if (model_pix(a) == FG) m_cnt++;
        check_int("model_fg_count", m_cnt, 454);
        check("model_pix_483", model_pix(483), FG);
        check("model_pix_243", model_pix(243), BG);

        // Full sweep; douta after the edge at iteration a belongs to a-1.
        fg_cnt = 0;
        for (int a = 0; a <= 1176; a++) begin
            @(posedge clk);
            #1;
            if (a > 0 && douta == FG) fg_cnt++;
            if (a < 1176) addra = 16'(a);
        end
        check_int("sweep_fg_count", fg_cnt, 454);

        // Reset for one edge mid-sweep at address 483.
        for (int a = 470; a <= 500; a++) begin
            @(posedge clk);
            #1;
            if (a == 484) check("rst_mid", douta, BG);
            if (a == 485) check("after_rst_mid", douta, FG);
            addra = 16'(a);
            rst   = (a == 483);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) addra = 16'($urandom);
            else                           addra = 16'($urandom_range(0, 1250));
            rst = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
